// File: rtl/bus_arbiter_if.sv
// Bus bundle between two masters, the arbiter and the slave.
// Lock inputs exist only when BUS_ARB_LOCK_EN is defined.
interface bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  m0Req;
  logic                  m0WriteEnable;
  logic [ADDR_WIDTH-1:0] m0Address;
  logic [DATA_WIDTH-1:0] m0DataOut;
  logic [DATA_WIDTH-1:0] m0DataIn;
  logic                  m0Ack;
  logic                  m1Req;
  logic                  m1WriteEnable;
  logic [ADDR_WIDTH-1:0] m1Address;
  logic [DATA_WIDTH-1:0] m1DataOut;
  logic [DATA_WIDTH-1:0] m1DataIn;
  logic                  m1Ack;
  logic [ADDR_WIDTH-1:0] busAddress;
  logic [DATA_WIDTH-1:0] busDataOut;
  logic [DATA_WIDTH-1:0] busDataIn;
  logic                  busWriteEnable;
  logic                  owner;
  logic                  busy;
`ifdef BUS_ARB_LOCK_EN
  logic                  m0Lock;
  logic                  m1Lock;
`endif

  modport slave (
`ifdef BUS_ARB_LOCK_EN
    input  m0Lock, m1Lock,
`endif
    input  m0Req, m0WriteEnable, m0Address, m0DataOut,
    input  m1Req, m1WriteEnable, m1Address, m1DataOut,
    input  busDataIn,
    output m0DataIn, m0Ack, m1DataIn, m1Ack,
    output busAddress, busDataOut, busWriteEnable,
    output owner, busy
  );

  modport master (
`ifdef BUS_ARB_LOCK_EN
    output m0Lock, m1Lock,
`endif
    output m0Req, m0WriteEnable, m0Address, m0DataOut,
    output m1Req, m1WriteEnable, m1Address, m1DataOut,
    output busDataIn,
    input  m0DataIn, m0Ack, m1DataIn, m1Ack,
    input  busAddress, busDataOut, busWriteEnable,
    input  owner, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with fixed slave wait states.
// Define BUS_ARB_LOCK_EN to add master locks for atomic sequences.
module bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32
) (
  input logic         clk,
  input logic         reset,
  bus_arbiter_if.slave bus
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
`ifdef BUS_ARB_LOCK_EN
    , S_LOCKED
`endif
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner;
  logic                  r_last;
  logic                  r_we;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_m0Data;
  logic [DATA_WIDTH-1:0] r_m1Data;
  logic                  w_grant;
  logic                  w_win;
  logic                  w_done;
  logic                  w_access;
  logic                  w_ack;

`ifdef BUS_ARB_LOCK_EN
  logic w_ownReq;
  logic w_ownLock;
  assign w_ownReq  = r_owner ? bus.m1Req  : bus.m0Req;
  assign w_ownLock = r_owner ? bus.m1Lock : bus.m0Lock;
`endif

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_win   = r_owner;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          bus.m0Req && bus.m1Req: begin
            w_grant = 1'b1;
            w_win   = ~r_last;
          end
          bus.m0Req && !bus.m1Req: begin
            w_grant = 1'b1;
            w_win   = 1'b0;
          end
          !bus.m0Req && bus.m1Req: begin
            w_grant = 1'b1;
            w_win   = 1'b1;
          end
          default: ;
        endcase
        if (w_grant) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_done = 1'b1;
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        w_next = S_IDLE;
`ifdef BUS_ARB_LOCK_EN
        if (w_ownLock) w_next = S_LOCKED;
`endif
      end
`ifdef BUS_ARB_LOCK_EN
      // Only the lock holder can be granted; the other master waits.
      S_LOCKED: begin
        if (w_ownReq) begin
          w_grant = 1'b1;
          w_win   = r_owner;
          w_next  = S_ACCESS;
        end else if (!w_ownLock) begin
          w_next = S_IDLE;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b1;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_m0Data <= '0;
      r_m1Data <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner <= w_win;
        r_cnt   <= LP_WAIT;
        r_addr  <= w_win ? bus.m1Address : bus.m0Address;
        r_wdata <= w_win ? bus.m1DataOut : bus.m0DataOut;
        r_we    <= w_win ? bus.m1WriteEnable
                         : bus.m0WriteEnable;
      end else if (w_access && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done && !r_we) begin
        if (r_owner) r_m1Data <= bus.busDataIn;
        else         r_m0Data <= bus.busDataIn;
      end
      if (w_ack) r_last <= r_owner;
    end
  end

  assign w_access = (r_state == S_ACCESS);
  assign w_ack    = (r_state == S_ACK);

  assign bus.busAddress     = w_access ? r_addr  : '0;
  assign bus.busDataOut     = w_access ? r_wdata : '0;
  assign bus.busWriteEnable = w_access && r_we;
  assign bus.m0Ack          = w_ack && !r_owner;
  assign bus.m1Ack          = w_ack && r_owner;
  assign bus.m0DataIn       = r_m0Data;
  assign bus.m1DataIn       = r_m1Data;
  assign bus.owner          = r_owner;
  assign bus.busy           = w_access || w_ack;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter.
// Lock scenario runs only when BUS_ARB_LOCK_EN is defined.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;
  int   who;
  int   lat0;
  int   lat3;

  always #5 clk = ~clk;

  bus_arbiter_if bus ();
  bus_arbiter_if b0 ();
  bus_arbiter_if b3 ();

  bus_arbiter #(.WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  bus_arbiter #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  bus_arbiter #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int w);
    w = -1;
    for (int c = 0; c < 12 && w < 0; c++) begin
      tick();
      chk("both_ack", 32'(bus.m0Ack && bus.m1Ack), 32'd0);
      if (bus.m0Ack) w = 0;
      else if (bus.m1Ack) w = 1;
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.m0Req = 0; bus.m0WriteEnable = 0;
    bus.m0Address = 0; bus.m0DataOut = 0;
    bus.m1Req = 0; bus.m1WriteEnable = 0;
    bus.m1Address = 0; bus.m1DataOut = 0;
    bus.busDataIn = 0;
    b0.m0Req = 0; b0.m0WriteEnable = 0;
    b0.m0Address = 0; b0.m0DataOut = 0;
    b0.m1Req = 0; b0.m1WriteEnable = 0;
    b0.m1Address = 0; b0.m1DataOut = 0;
    b0.busDataIn = 0;
    b3.m0Req = 0; b3.m0WriteEnable = 0;
    b3.m0Address = 0; b3.m0DataOut = 0;
    b3.m1Req = 0; b3.m1WriteEnable = 0;
    b3.m1Address = 0; b3.m1DataOut = 0;
    b3.busDataIn = 0;
`ifdef BUS_ARB_LOCK_EN
    bus.m0Lock = 0; bus.m1Lock = 0;
    b0.m0Lock = 0; b0.m1Lock = 0;
    b3.m0Lock = 0; b3.m1Lock = 0;
`endif
    tick();
    tick();
    chk("rst_owner", 32'(bus.owner), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_addr", bus.busAddress, 32'd0);
    chk("rst_we", 32'(bus.busWriteEnable), 32'd0);
    chk("rst_d0", bus.m0DataIn, 32'd0);
    reset = 1'b1;
    tick();

    // m0 read, WAIT_STATES=1
    bus.m0Req = 1; bus.m0Address = 32'h10;
    bus.busDataIn = 32'hDEADBEEF;
    tick();
    chk("rd_a1", bus.busAddress, 32'h10);
    chk("rd_busy1", 32'(bus.busy), 32'd1);
    chk("rd_ack1", 32'(bus.m0Ack), 32'd0);
    tick();
    chk("rd_a2", bus.busAddress, 32'h10);
    chk("rd_ack2", 32'(bus.m0Ack), 32'd0);
    tick();
    chk("rd_ack3", 32'(bus.m0Ack), 32'd1);
    chk("rd_a3", bus.busAddress, 32'd0);
    chk("rd_d0", bus.m0DataIn, 32'hDEADBEEF);
    chk("rd_d1", bus.m1DataIn, 32'd0);
    bus.m0Req = 0;
    tick();
    chk("rd_ack4", 32'(bus.m0Ack), 32'd0);
    chk("rd_idle", 32'(bus.busy), 32'd0);

    // round-robin from a fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.m0Req = 1; bus.m1Req = 1;
    bus.m0Address = 32'h100; bus.m1Address = 32'h200;
    bus.busDataIn = 32'hA5A50001;
    for (int t = 0; t < 8; t++) begin
      wait_ack(who);
      chk("rr_who", 32'(who), 32'(t % 2));
      chk("rr_owner", 32'(bus.owner), 32'(t % 2));
    end
    bus.m0Req = 0; bus.m1Req = 0;
    tick();
    chk("rr_d1", bus.m1DataIn, 32'hA5A50001);

    // m1 write; fields latched at grant
    bus.m1Req = 1; bus.m1WriteEnable = 1;
    bus.m1Address = 32'h80000004;
    bus.m1DataOut = 32'h12345678;
    bus.busDataIn = 32'h0BADF00D;
    tick();
    chk("wr_we1", 32'(bus.busWriteEnable), 32'd1);
    chk("wr_a1", bus.busAddress, 32'h80000004);
    chk("wr_d1", bus.busDataOut, 32'h12345678);
    bus.m1Address = 32'h0; bus.m1DataOut = 32'h0;
    tick();
    chk("wr_we2", 32'(bus.busWriteEnable), 32'd1);
    chk("wr_a2", bus.busAddress, 32'h80000004);
    chk("wr_d2", bus.busDataOut, 32'h12345678);
    tick();
    chk("wr_ack", 32'(bus.m1Ack), 32'd1);
    chk("wr_we3", 32'(bus.busWriteEnable), 32'd0);
    chk("wr_keep", bus.m1DataIn, 32'hA5A50001);
    bus.m1Req = 0; bus.m1WriteEnable = 0;
    tick();

    // reset during second ACCESS cycle
    bus.m0Req = 1; bus.m0Address = 32'h20;
    tick();
    tick();
    chk("ab_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0; bus.m0Req = 0;
    tick();
    chk("ab_busy0", 32'(bus.busy), 32'd0);
    chk("ab_addr", bus.busAddress, 32'd0);
    chk("ab_ack", 32'(bus.m0Ack), 32'd0);
    chk("ab_owner", 32'(bus.owner), 32'd1);
    chk("ab_d0", bus.m0DataIn, 32'd0);
    chk("ab_d1", bus.m1DataIn, 32'd0);
    reset = 1'b1;
    tick();
    chk("ab_noack", 32'(bus.m0Ack), 32'd0);
    bus.m0Req = 1; bus.m0Address = 32'h30;
    bus.busDataIn = 32'hCAFEF00D;
    wait_ack(who);
    chk("ab_who", 32'(who), 32'd0);
    chk("ab_rd", bus.m0DataIn, 32'hCAFEF00D);
    bus.m0Req = 0;
    tick();

    // latency for WAIT_STATES 0 and 3
    b0.m0Req = 1; b3.m0Req = 1;
    lat0 = 0; lat3 = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (b0.m0Ack && lat0 == 0) lat0 = c;
      if (b3.m0Ack && lat3 == 0) lat3 = c;
    end
    chk("lat_w0", 32'(lat0), 32'd2);
    chk("lat_w3", 32'(lat3), 32'd5);
    b0.m0Req = 0; b3.m0Req = 0;
    tick();

`ifdef BUS_ARB_LOCK_EN
    // m1 holds the bus for two reads while m0 waits
    bus.m0Req = 1; bus.m1Req = 1; bus.m1Lock = 1;
    wait_ack(who);
    chk("lk_first", 32'(who), 32'd1);
    wait_ack(who);
    chk("lk_second", 32'(who), 32'd1);
    bus.m1Lock = 0; bus.m1Req = 0;
    wait_ack(who);
    chk("lk_m0", 32'(who), 32'd0);
    bus.m0Req = 0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
